wb_arbiter: RTL and testbench

- Write-back initiator for the core's 32x32 register file; owns its single write port.
- Merges two result sources into that one port:
  - Port A: single-cycle ALU results. Highest priority, no backpressure.
  - Port B: long-latency results (load / mul-div). valid/ready handshake, buffered in a small FIFO.
- Exports a pending-destination mask so the issue stage can stall on RAW/WAW hazards.

---
 rtl/wb_arbiter_pkg.sv | 19 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_arbiter.sv | 105 ++++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the register-file write-back path.
package wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is never a real destination, so it never contributes a hazard bit.
  function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return (rd == REG_ZERO) ? 32'd0 : (32'd1 << rd);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests; exposes per-entry rd for hazard tracking.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  wb_req_t                       push_req,
  input  logic                          pop,
  output wb_req_t                       head,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: an entry is only meaningful while entry_valid says so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    logic [PTR_W-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count_q);
      entry_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results win, long-latency results queue or bypass.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  input  logic [4:0]             a_rd,
  input  logic [XLEN-1:0]        a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [4:0]             b_rd,
  input  logic [XLEN-1:0]        b_data,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [31:0]            pending_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import wb_arbiter_pkg::*;

  wb_req_t                         fifo_head;
  wb_req_t                         b_req;
  wb_req_t                         sel_req;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [DEPTH-1:0]                entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;

  logic a_sel;
  logic b_fire;
  logic b_keep;
  logic sel_we;
  logic pop;
  logic bypass;
  logic push;

  assign b_req   = '{rd: b_rd, data: b_data};
  // Ready looks only at occupancy, never at a same-cycle pop, to keep it off the select path.
  assign b_ready = !fifo_full;
  assign b_fire  = b_valid && b_ready;
  assign b_keep  = b_fire && (b_rd != REG_ZERO);
  assign a_sel   = a_valid && (a_rd != REG_ZERO);

  always_comb begin
    sel_we  = 1'b0;
    sel_req = '{rd: a_rd, data: a_data};
    pop     = 1'b0;
    bypass  = 1'b0;
    if (a_sel) begin
      sel_we = 1'b1;
    end else if (!fifo_empty) begin
      sel_we  = 1'b1;
      sel_req = fifo_head;
      pop     = 1'b1;
    end else if (b_keep) begin
      sel_we  = 1'b1;
      sel_req = b_req;
      bypass  = 1'b1;
    end
  end

  assign push = b_keep && !bypass;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_req    (b_req),
    .pop         (pop),
    .head        (fifo_head),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= sel_we;
      if (sel_we) begin
        rf_waddr <= sel_req.rd;
        rf_wdata <= sel_req.data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask = pending_mask | rd_onehot(entry_rd[i]);
    end
    if (rf_we) pending_mask = pending_mask | rd_onehot(rf_waddr);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, corner sequences and random traffic vs a queue model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, b_ready, rf_we;
  logic [4:0]  a_rd, b_rd, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata, pending_mask;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of buffered requests plus the output stage.
  wb_req_t     mq[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        last_acc;

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic bv; logic [4:0] brd; logic [31:0] bd;
    logic e_ready; logic e_we; logic [4:0] e_waddr; logic [31:0] e_wdata;
    logic [31:0] e_mask; int e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'd0;
    foreach (mq[i]) if (mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
    if (m_we && m_waddr != 5'd0) m[m_waddr] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
  endtask

  task automatic model_step(input logic rdy);
    logic fire, taken;
    wb_req_t h;
    fire  = b_valid && rdy;
    taken = 1'b0;
    m_we  = 1'b1;
    if (a_valid && a_rd != 5'd0) begin
      m_waddr = a_rd; m_wdata = a_data;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_waddr = h.rd; m_wdata = h.data;
    end else if (fire && b_rd != 5'd0) begin
      m_waddr = b_rd; m_wdata = b_data; taken = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (fire && b_rd != 5'd0 && !taken) mq.push_back('{rd: b_rd, data: b_data});
  endtask

  // One clock: check ready before the edge, advance model at the edge, check state after it.
  task automatic cycle();
    logic rdy;
    logic [31:0] mm;
    #1;
    rdy = (mq.size() < DEPTH);
    mm  = model_mask();
    chk("b_ready", b_ready, rdy);
    if (a_valid && a_rd != 5'd0 && mm[a_rd]) begin
      errors++;
      $display("FAIL protocol: A dispatched to pending rd %0d", a_rd);
    end
    last_acc = b_valid && rdy;
    @(posedge clk);
    model_step(rdy);
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("pending_mask", pending_mask, model_mask());
    chk("fifo_count", fifo_count, mq.size());
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                              input logic er, input logic ew, input logic [4:0] ea,
                              input logic [31:0] ed, input logic [31:0] em, input int ec);
    vec_t v;
    v = '{av, ard, ad, bv, brd, bd, er, ew, ea, ed, em, ec};
    return v;
  endfunction

  initial begin
    model_reset();
    last_acc = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("reset rf_we", rf_we, 0);
    chk("reset b_ready", b_ready, 1);
    chk("reset pending_mask", pending_mask, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset rf_waddr", rf_waddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Directed vector table; expected outputs are the state after the edge.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 1, 5, 32'hDEADBEEF, 32'h20, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                 1, 0, 5, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 7, 32'h11,            1, 1, 7, 32'h11, 32'h80, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                 1, 0, 7, 32'h11, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h55,            1, 0, 7, 32'h11, 32'h0, 0));
    vecs.push_back(mk(1, 10, 32'hA0, 1, 1, 32'hB1,      1, 1, 10, 32'hA0, 32'h402, 1));
    vecs.push_back(mk(1, 11, 32'hA1, 1, 2, 32'hB2,      1, 1, 11, 32'hA1, 32'h806, 2));
    vecs.push_back(mk(1, 12, 32'hA2, 1, 3, 32'hB3,      1, 1, 12, 32'hA2, 32'h100E, 3));
    vecs.push_back(mk(1, 13, 32'hA3, 1, 4, 32'hB4,      1, 1, 13, 32'hA3, 32'h201E, 4));
    vecs.push_back(mk(1, 14, 32'hA4, 1, 5, 32'hB5,      0, 1, 14, 32'hA4, 32'h401E, 4));
    vecs.push_back(mk(1, 15, 32'hA5, 1, 5, 32'hB5,      0, 1, 15, 32'hA5, 32'h801E, 4));
    vecs.push_back(mk(0, 0, 0, 1, 5, 32'hB5,            0, 1, 1, 32'hB1, 32'h1E, 3));
    vecs.push_back(mk(0, 0, 0, 1, 5, 32'hB5,            1, 1, 2, 32'hB2, 32'h3C, 3));
    vecs.push_back(mk(0, 0, 0, 1, 6, 32'hB6,            1, 1, 3, 32'hB3, 32'h78, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                 1, 1, 4, 32'hB4, 32'h70, 2));
    vecs.push_back(mk(1, 0, 32'hBAD, 0, 0, 0,           1, 1, 5, 32'hB5, 32'h60, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                 1, 1, 6, 32'hB6, 32'h40, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                 1, 0, 6, 32'hB6, 32'h0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd);
      #1;
      chk("tbl b_ready", b_ready, vecs[i].e_ready);
      cycle();
      chk("tbl rf_we", rf_we, vecs[i].e_we);
      chk("tbl rf_waddr", rf_waddr, vecs[i].e_waddr);
      chk("tbl rf_wdata", rf_wdata, vecs[i].e_wdata);
      chk("tbl pending_mask", pending_mask, vecs[i].e_mask);
      chk("tbl fifo_count", fifo_count, vecs[i].e_cnt);
    end

    // x0 A must not block the drain of a buffered rd=9.
    drive(1, 20, 32'h20, 1, 9, 32'h99);
    cycle();
    chk("x0 buffered", fifo_count, 1);
    drive(1, 0, 32'hBAD0, 0, 0, 0);
    cycle();
    chk("x0 drain we", rf_we, 1);
    chk("x0 drain addr", rf_waddr, 9);
    chk("x0 drain data", rf_wdata, 32'h99);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // Random traffic against the model.
    b_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] mm;
      logic [4:0]  r;
      if (!b_valid || last_acc) begin
        b_valid = ($urandom_range(0, 99) < 55);
        b_rd    = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      mm = model_mask();
      r  = 5'($urandom_range(0, 31));
      a_valid = ($urandom_range(0, 99) < 50);
      a_rd    = mm[r] ? 5'd0 : r;
      a_data  = $urandom;
      cycle();
    end

    drive(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 8; n++) cycle();

    // Reset mid-operation with three buffered entries and a write in flight.
    drive(1, 20, 32'h120, 1, 1, 32'hC1); cycle();
    drive(1, 21, 32'h121, 1, 2, 32'hC2); cycle();
    drive(1, 22, 32'h122, 1, 3, 32'hC3); cycle();
    chk("pre-reset count", fifo_count, 3);
    drive(1, 23, 32'h123, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rf_we", rf_we, 0);
    chk("async fifo_count", fifo_count, 0);
    chk("async pending_mask", pending_mask, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cycle();
      chk("no stale write", rf_we, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
